// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter in front of a single-ported SRAM controller.
// Each access runs IDLE -> BUSY -> RELEASE; the winner's request is latched so the controller sees a stable transaction.
module sram_arbiter #(
   parameter logic INIT_LAST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_read_en,
   input  logic        p0_write_en,
   input  logic [31:0] p0_address,
   input  logic [31:0] p0_writeData,
   output logic [31:0] p0_readData,
   output logic        p0_ready,
   input  logic        p1_read_en,
   input  logic        p1_write_en,
   input  logic [31:0] p1_address,
   input  logic [31:0] p1_writeData,
   output logic [31:0] p1_readData,
   output logic        p1_ready,
   output logic        mem_read_en,
   output logic        mem_write_en,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writeData,
   input  logic [31:0] mem_readData,
   input  logic        mem_ready,
   output logic [1:0]  grant,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   state_t      state, next_state;
   logic        owner;
   logic        last_grant;
   logic        op;
   logic        first_cycle;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic        pend0, pend1;
   logic        winner;
   logic        done;

   assign pend0  = p0_read_en | p0_write_en;
   assign pend1  = p1_read_en | p1_write_en;
   // On a tie the port that did not win last time goes next; otherwise whoever is asking.
   assign winner = (pend0 && pend1) ? ~last_grant : pend1;
   assign done   = (state == BUSY) && !first_cycle && mem_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (pend0 || pend1) next_state = BUSY;
         BUSY:    if (done) next_state = RELEASE;
         RELEASE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner       <= 1'b0;
         last_grant  <= INIT_LAST;
         op          <= 1'b0;
         first_cycle <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         p0_readData <= '0;
         p1_readData <= '0;
      end else begin
         if (state == IDLE && (pend0 || pend1)) begin
            owner       <= winner;
            last_grant  <= winner;
            addr_q      <= winner ? p1_address   : p0_address;
            data_q      <= winner ? p1_writeData : p0_writeData;
            op          <= winner ? p1_write_en  : p0_write_en;
            first_cycle <= 1'b1;
         end else if (state == BUSY) begin
            first_cycle <= 1'b0;
         end
         if (done && !op) begin
            if (owner) p1_readData <= mem_readData;
            else       p0_readData <= mem_readData;
         end
      end
   end

   // Controller-facing signals are gated by state so they drop immediately on reset.
   always_comb begin
      mem_read_en   = 1'b0;
      mem_write_en  = 1'b0;
      mem_address   = '0;
      mem_writeData = '0;
      if (state == BUSY) begin
         mem_read_en   = ~op;
         mem_write_en  = op;
         mem_address   = addr_q;
         mem_writeData = data_q;
      end
   end

   assign grant    = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
   assign busy     = (state != IDLE);
   assign p0_ready = ~pend0 | (done & ~owner);
   assign p1_ready = ~pend1 | (done &  owner);

endmodule
